// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle for pipe_adder.
//   in_valid/in_ready/a/b/op : operand beat, producer -> adder
//   out_valid/out_ready/sum  : result beat, adder -> consumer
// master = producer/consumer side, slave = adder side.
interface pipe_adder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, sum
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, sum
  );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add / subtract / accumulate with valid-ready handshake.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, clears pipeline and accumulator
//   bus      : pipe_adder_if.slave
//              in_valid/in_ready, a, b, op (00 add, 01 sub, 10 acc+=a, 11 acc=0)
//              out_valid/out_ready, sum (WIDTH+1 bits, registered)
// Parameters: WIDTH operand width; STAGES register stages (1..4) from accept to output.
// Optional build macro PIPE_ADDER_SAT_EN: subtract clamps at 0, accumulate clamps at
// all-ones instead of wrapping. Without it both wrap modulo 2^(WIDTH+1).
module pipe_adder #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  pipe_adder_if.slave bus
);

  localparam int unsigned RW = WIDTH + 1;

  logic [STAGES-1:0] vld;
  logic [RW-1:0]     data [STAGES];
  logic [STAGES-1:0] rdy;        // rdy[k]: stage k may load this cycle
  logic              rdy_run;
  logic [RW-1:0]     acc;
  logic [RW-1:0]     acc_nxt;
  logic [RW-1:0]     result;
  logic [RW-1:0]     ext_a;
  logic [RW-1:0]     ext_b;
  logic              accept;

  assign ext_a = {1'b0, bus.a};
  assign ext_b = {1'b0, bus.b};

`ifdef PIPE_ADDER_SAT_EN
  // One extra bit so accumulate overflow is visible for clamping.
  logic [RW:0] acc_wide;
  assign acc_wide = {1'b0, acc} + {2'b00, bus.a};
`endif

  // Ready ripples back from the consumer: a stage can load if empty or draining.
  always_comb begin
    rdy     = '0;
    rdy_run = bus.out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      rdy_run = !vld[k] || rdy_run;
      rdy[k]  = rdy_run;
    end
  end

  assign bus.in_ready  = !rst && rdy[0];
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = vld[STAGES-1];
  assign bus.sum       = data[STAGES-1];

  // Arithmetic for the beat being accepted; also the accumulator's next value.
  always_comb begin
    result  = '0;
    acc_nxt = acc;
    case (bus.op)
      2'b00: result = ext_a + ext_b;
      2'b01: begin
`ifdef PIPE_ADDER_SAT_EN
        result = (bus.a < bus.b) ? '0 : (ext_a - ext_b);
`else
        result = ext_a - ext_b;
`endif
      end
      2'b10: begin
`ifdef PIPE_ADDER_SAT_EN
        acc_nxt = acc_wide[RW] ? '1 : acc_wide[RW-1:0];
`else
        acc_nxt = acc + ext_a;
`endif
        result = acc_nxt;
      end
      2'b11: begin
        acc_nxt = '0;
        result  = '0;
      end
      default: begin
        result  = '0;
        acc_nxt = acc;
      end
    endcase
  end

  // Pipeline registers; data only moves with a valid beat so sum holds across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      acc <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        data[k] <= '0;
      end
    end else begin
      if (accept) begin
        acc <= acc_nxt;
      end
      if (rdy[0]) begin
        vld[0] <= accept;
        if (accept) begin
          data[0] <= result;
        end
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (rdy[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) begin
            data[k] <= data[k-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: drives one stimulus stream into three pipe_adder instances
// (STAGES = 2, 1, 4). The STAGES=2 instance sees the bench's out_ready; the
// others always accept results and only take beats the STAGES=2 instance takes.
// Each instance has a scoreboard queue filled at accept from a reference model.
module tb_pipe_adder;

  localparam int unsigned W   = 4;
  localparam int          MOD = 1 << (W + 1);
`ifdef PIPE_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a_d;
  logic [W-1:0] b_d;
  logic [1:0]   op_d;
  logic         iv_d;
  logic         or_d;
  logic         rdy0;
  logic         done;
  int           checks = 0;
  int           fails  = 0;
  int           cyc    = 0;
  int           acc_cnt0 = 0;
  event         rst_ev;
  event         drain_ev;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: result of one op from plain integer arithmetic.
  function automatic int model(input int a, input int b, input int op,
                               input int acc_in, output int acc_out);
    int r;
    acc_out = acc_in;
    r = 0;
    case (op)
      0: r = a + b;
      1: r = SAT ? ((a < b) ? 0 : a - b) : ((a - b + MOD) % MOD);
      2: begin
        acc_out = acc_in + a;
        if (SAT) acc_out = (acc_out > MOD - 1) ? MOD - 1 : acc_out;
        else     acc_out = acc_out % MOD;
        r = acc_out;
      end
      default: begin
        acc_out = 0;
        r = 0;
      end
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned S = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    pipe_adder_if #(.WIDTH(W)) bus ();

    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    int         qexp[$];
    int         qedge[$];
    int         macc = 0;
    int         last_low = -1;
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    int         ps = 0;
    int         e_new;
    int         acc_new;
    int         e_exp;
    int         e_edge;

    assign bus.a  = a_d;
    assign bus.b  = b_d;
    assign bus.op = op_d;

    if (g == 0) begin : g_main
      assign bus.in_valid  = iv_d;
      assign bus.out_ready = or_d;
      assign rdy0          = bus.in_ready;
      always @(negedge clk) if (bus.in_valid && bus.in_ready) acc_cnt0 <= acc_cnt0 + 1;
    end else begin : g_side
      assign bus.in_valid  = iv_d && rdy0;
      assign bus.out_ready = 1'b1;
    end

    // Accept tap pushes expectations; output side pops and compares.
    always @(negedge clk) begin
      if (rst) begin
        qexp.delete();
        qedge.delete();
        macc <= 0;
        pv   <= 1'b0;
        pr   <= 1'b0;
      end else begin
        if (bus.in_valid && bus.in_ready) begin
          e_new = model(int'(bus.a), int'(bus.b), int'(bus.op), macc, acc_new);
          macc <= acc_new;
          qexp.push_back(e_new);
          qedge.push_back(cyc + 1);
        end
        if (pv && !pr) begin
          check($sformatf("stall_valid_s%0d", S), int'(bus.out_valid), 1);
          check($sformatf("stall_sum_s%0d", S), int'(bus.sum), ps);
        end
        if (bus.out_valid && bus.out_ready) begin
          check($sformatf("out_has_expect_s%0d", S), int'(qexp.size() > 0), 1);
          if (qexp.size() > 0) begin
            e_exp  = qexp.pop_front();
            e_edge = qedge.pop_front();
            check($sformatf("sum_s%0d", S), int'(bus.sum), e_exp);
            if (last_low < e_edge)
              check($sformatf("latency_s%0d", S), cyc - e_edge, int'(S) - 1);
          end
        end
        if (!bus.out_ready) last_low <= cyc;
        pv <= bus.out_valid;
        pr <= bus.out_ready;
        ps <= int'(bus.sum);
      end
    end

    always @(rst_ev) begin
      check($sformatf("rst_out_valid_s%0d", S), int'(bus.out_valid), 0);
      check($sformatf("rst_sum_s%0d", S), int'(bus.sum), 0);
      check($sformatf("rst_in_ready_s%0d", S), int'(bus.in_ready), 0);
    end

    always @(drain_ev) check($sformatf("drained_s%0d", S), qexp.size(), 0);
  end

  // Present one beat and hold it until the STAGES=2 instance takes it.
  task automatic send(input int a, input int b, input int op);
    int   n;
    logic ok;
    a_d  = W'(a);
    b_d  = W'(b);
    op_d = 2'(op);
    iv_d = 1'b1;
    n    = 0;
    forever begin
      @(negedge clk);
      ok = rdy0;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 50) begin
        check("send_timeout", n, 0);
        break;
      end
    end
    iv_d = 1'b0;
  endtask

  task automatic idle(input int n);
    iv_d = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    rst  = 1'b1;
    iv_d = 1'b0;
    a_d  = '0;
    b_d  = '0;
    op_d = '0;
    or_d = 1'b1;
    done = 1'b0;
    repeat (2) @(posedge clk);
    #1 -> rst_ev;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Legacy add vectors, then subtract with and without borrow.
    send(3, 5, 0);
    send(15, 1, 0);
    send(6, 6, 0);
    idle(6);
    send(5, 3, 1);
    send(3, 5, 1);
    idle(4);

    // Accumulate: clear, then 15 three times.
    send(0, 0, 3);
    repeat (3) send(15, 0, 2);
    idle(6);

    // Backpressure: six adds against a stalled consumer for five cycles.
    or_d = 1'b0;
    base = acc_cnt0;
    fork
      for (int i = 0; i < 6; i++) send(i + 1, 2 * i, 0);
      begin
        repeat (5) @(posedge clk);
        #1;
        check("bp_in_ready", int'(rdy0), 0);
        check("bp_accepts", acc_cnt0 - base, 2);
        or_d = 1'b1;
      end
    join
    idle(8);

    // Reset with two beats in flight, then a fresh accumulate.
    or_d = 1'b0;
    send(1, 2, 0);
    send(3, 4, 0);
    rst = 1'b1;
    #1 -> rst_ev;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    or_d = 1'b1;
    send(1, 0, 2);
    idle(6);

    // Back-to-back adds with the consumer always ready.
    for (int i = 0; i < 20; i++) send($urandom_range(0, 15), $urandom_range(0, 15), 0);
    idle(6);

    // Random ops with random consumer stalls.
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        done = 1'b1;
      end
      while (!done) begin
        or_d = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
      end
    join

    or_d = 1'b1;
    idle(12);
    -> drain_ev;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
